// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated adder.
// Consumers use rsp_t to carry a result together with its requester id.
package adder_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_A_WIDTH   = 16;
    localparam int DEF_B_WIDTH   = 16;
    localparam int DEF_OUT_WIDTH = ((DEF_A_WIDTH > DEF_B_WIDTH) ? DEF_A_WIDTH : DEF_B_WIDTH) + 1;

    // $clog2(1) is 0, which would give a zero-width index bus.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_WIDTH = clog2_min1(DEF_NUM_REQ);

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    typedef struct packed {
        logic signed [DEF_OUT_WIDTH-1:0] data;
        logic        [DEF_ID_WIDTH-1:0]  id;
    } rsp_t;

endpackage

// File: rtl/adder.sv
// Combinational signed adder with arithmetic right-shift scaling.
// Result = low OUT_WIDTH bits of floor((a + b) / 2**OUT_SCALE).
module adder #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
    parameter int OUT_SCALE = 0
) (
    input  logic signed [A_WIDTH-1:0]   a,
    input  logic signed [B_WIDTH-1:0]   b,
    output logic signed [OUT_WIDTH-1:0] sum
);

    // Only bits [OUT_SCALE +: OUT_WIDTH] of the exact sum survive, and the low
    // bits of a two's-complement sum depend only on the low operand bits, so
    // adding at this width matches the full-width sum-then-shift exactly.
    localparam int EXT_W = OUT_WIDTH + OUT_SCALE;

    logic signed [EXT_W-1:0] a_ext;
    logic signed [EXT_W-1:0] b_ext;
    logic signed [EXT_W-1:0] sum_ext;

    assign a_ext   = EXT_W'(a);
    assign b_ext   = EXT_W'(b);
    assign sum_ext = a_ext + b_ext;

    // Dropping the low bits of a two's-complement value floors toward -inf.
    assign sum = sum_ext[EXT_W-1:OUT_SCALE];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority scan: first asserted request at or after ptr wins.
// grant is one-hot and gated by en; idx and any are reported regardless of en.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    input  logic                 en,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    logic                 found;
    logic [IDX_WIDTH-1:0] cand;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (en && found) begin
            grant[idx] = 1'b1;
        end
    end

    assign any = found;

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one adder between NUM_REQ valid/ready requesters via round-robin
// arbitration; results leave through a single registered, id-tagged channel.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
    parameter int OUT_SCALE = 0,
    parameter int ID_WIDTH  = clog2_min1(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic signed [OUT_WIDTH-1:0]  rsp_data,
    output logic [ID_WIDTH-1:0]          rsp_id
);

    rsp_state_t                  state;
    logic [ID_WIDTH-1:0]         ptr;
    logic [ID_WIDTH-1:0]         ptr_next;
    logic [ID_WIDTH-1:0]         grant_idx;
    logic                        grant_any;
    logic                        slot_free;
    logic                        accept;
    logic signed [A_WIDTH-1:0]   a_arr [NUM_REQ];
    logic signed [B_WIDTH-1:0]   b_arr [NUM_REQ];
    logic signed [A_WIDTH-1:0]   a_sel;
    logic signed [B_WIDTH-1:0]   b_sel;
    logic signed [OUT_WIDTH-1:0] sum;

    assign rsp_valid = (state == RSP_FULL);

    // The output slot can take a new result when empty or being drained this
    // cycle; reset blocks every handshake.
    assign slot_free = !rst && (!rsp_valid || rsp_ready);
    assign accept    = slot_free && grant_any;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (ID_WIDTH)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (slot_free),
        .grant (req_ready),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*A_WIDTH +: A_WIDTH];
            b_arr[i] = req_b[i*B_WIDTH +: B_WIDTH];
        end
    end

    assign a_sel = a_arr[grant_idx];
    assign b_sel = b_arr[grant_idx];

    adder #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SCALE (OUT_SCALE)
    ) u_adder (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum)
    );

    assign ptr_next = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RSP_EMPTY;
            rsp_data <= '0;
            rsp_id   <= '0;
            ptr      <= '0;
        end else if (accept) begin
            state    <= RSP_FULL;
            rsp_data <= sum;
            rsp_id   <= grant_idx;
            ptr      <= ptr_next;
        end else if (rsp_ready) begin
            state    <= RSP_EMPTY;
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized plus directed bench for adder_rr_arbiter against a behavioural model.
// A second instance with OUT_SCALE=2 shares all inputs to exercise scaling.
module tb_adder_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int BW = 16;
    localparam int OW = 17;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_ready_s;
    logic [N*AW-1:0]   req_a;
    logic [N*BW-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_valid_s;
    logic              rsp_ready;
    logic [OW-1:0]     rsp_data;
    logic [OW-1:0]     rsp_data_s;
    logic [IW-1:0]     rsp_id;
    logic [IW-1:0]     rsp_id_s;

    always #5 clk = ~clk;

    adder_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    adder_rr_arbiter #(.OUT_SCALE(2)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready_s),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid_s),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data_s),
        .rsp_id    (rsp_id_s)
    );

    int n_vec = 0;
    int n_err = 0;

    int op_a [N];
    int op_b [N];

    // Reference model: contents of the output slot and the next-priority requester.
    bit            m_valid;
    int            m_id;
    logic [OW-1:0] m_d0;
    logic [OW-1:0] m_d2;
    int            m_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] f(input int a, input int b, input int sh);
        int s;
        s = (a + b) >>> sh;
        return OW'(s);
    endfunction

    function automatic int find_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive at the falling edge, compare just after, then advance.
    task automatic tick(input logic rst_i, input logic [N-1:0] v, input logic rr);
        bit           en;
        int           g;
        logic [N-1:0] er;
        rst       = rst_i;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(op_a[i]);
            req_b[i*BW +: BW] = BW'(op_b[i]);
        end
        #1;
        en = !rst_i && (!m_valid || rr);
        g  = find_grant(v, m_ptr);
        er = '0;
        if (en && g >= 0) er[g] = 1'b1;

        check("req_ready", 32'(req_ready), 32'(er));
        check("req_ready_s", 32'(req_ready_s), 32'(er));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_data", 32'(rsp_data), 32'(m_d0));
        check("rsp_data_s", 32'(rsp_data_s), 32'(m_d2));

        if (rst_i) begin
            m_valid = 1'b0;
            m_id    = 0;
            m_d0    = '0;
            m_d2    = '0;
            m_ptr   = 0;
        end else if (er != '0) begin
            m_valid = 1'b1;
            m_id    = g;
            m_d0    = f(op_a[g], op_b[g], 0);
            m_d2    = f(op_a[g], op_b[g], 2);
            m_ptr   = (g + 1) % N;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            op_a[i] = int'($urandom_range(0, 65535)) - 32768;
            op_b[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = 0;
            op_b[i] = 0;
        end
        m_valid = 1'b0;
        m_id    = 0;
        m_d0    = '0;
        m_d2    = '0;
        m_ptr   = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset state, with requests present while rst is high.
        tick(1'b1, 4'b1111, 1'b1);
        tick(1'b1, 4'b0000, 1'b1);

        // Single request: 5 + -3 = 2 from requester 0.
        op_a[0] = 5;
        op_b[0] = -3;
        tick(1'b0, 4'b0001, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);

        // Round robin from ptr=0 with all requesters active.
        tick(1'b1, 4'b0000, 1'b1);
        rand_ops();
        for (int c = 0; c < 6; c++) tick(1'b0, 4'b1111, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);

        // Backpressure for three cycles, then release.
        rand_ops();
        tick(1'b0, 4'b1111, 1'b1);
        for (int c = 0; c < 3; c++) tick(1'b0, 4'b1111, 1'b0);
        tick(1'b0, 4'b1111, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);

        // Scaling and extremes on requester 0.
        op_a[0] = -7;     op_b[0] = 0;
        tick(1'b0, 4'b0001, 1'b1);
        op_a[0] = 32767;  op_b[0] = 32767;
        tick(1'b0, 4'b0001, 1'b1);
        op_a[0] = -32768; op_b[0] = -32768;
        tick(1'b0, 4'b0001, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);

        // Skip idle requesters: ptr=1, only 0 and 3 request.
        tick(1'b1, 4'b0000, 1'b1);
        rand_ops();
        tick(1'b0, 4'b0001, 1'b1);
        tick(1'b0, 4'b1001, 1'b1);
        tick(1'b0, 4'b1001, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);

        // Reset during a stall drops the pending result and the pointer.
        rand_ops();
        tick(1'b0, 4'b0100, 1'b1);
        tick(1'b0, 4'b1111, 1'b0);
        tick(1'b1, 4'b1111, 1'b0);
        tick(1'b0, 4'b1111, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            tick(($urandom_range(0, 63) == 0),
                 N'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
